approx_booth_multiplier: RTL and testbench

- Approximate signed 16x16 multiplier producing a 32-bit two's-complement product.
- Used in the fixed-point datapath. The consumer applies any arithmetic right shift (fixed-point scaling) outside this block.
- Approximation: partial-product bits in the low TRUNC_COLS columns of a radix-4 Booth array are dropped, and a constant bias compensation is added.
- Single registered output stage.

---
 rtl/approx_mult_pkg.sv | 72 +++++++
 rtl/booth_pp_gen.sv | 45 ++++
 rtl/approx_booth_multiplier.sv | 90 +++++++++
 tb/tb_approx_booth_multiplier.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared definitions for the approximate radix-4 Booth multiplier.
//   - booth_digit_t : one recoded Booth digit as {neg, one, two} flags
//   - booth_recode  : maps a 3-bit window {B[2i+1],B[2i],B[2i-1]} to a digit
//   - booth_golden  : bit-accurate reference for the truncated/compensated product
package approx_mult_pkg;

    localparam int DEF_WIDTH      = 16;
    localparam int DEF_TRUNC_COLS = 8;
    localparam int DEF_PW         = 2 * DEF_WIDTH;

    // Digit value = (neg ? -1 : +1) * (two ? 2 : one ? 1 : 0)
    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    // A window of 111 is digit 0, not -0: neg must stay low so no stray
    // inverted row appears in the truncated columns.
    function automatic booth_digit_t booth_recode(input logic [2:0] bits);
        booth_digit_t d;
        d.one = bits[1] ^ bits[0];
        d.two = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
        d.neg = bits[2] & ~(bits[1] & bits[0]);
        return d;
    endfunction

    function automatic logic [DEF_PW-1:0] booth_golden(
        input logic [DEF_WIDTH-1:0] a,
        input logic [DEF_WIDTH-1:0] b,
        input int                   trunc_cols
    );
        logic [DEF_WIDTH:0]  b_ext;
        logic [DEF_WIDTH:0]  mag;
        logic [DEF_PW-1:0]   row;
        logic [DEF_PW-1:0]   keep;
        logic [DEF_PW-1:0]   acc;
        booth_digit_t        d;
        b_ext = {b, 1'b0};
        keep  = {DEF_PW{1'b1}} << trunc_cols;
        acc   = {DEF_PW{1'b0}};
        for (int i = 0; i < DEF_WIDTH / 2; i++) begin
            d = booth_recode(b_ext[2*i +: 3]);
            if (d.two) begin
                mag = {a, 1'b0};
            end else if (d.one) begin
                mag = {a[DEF_WIDTH-1], a};
            end else begin
                mag = {(DEF_WIDTH+1){1'b0}};
            end
            if (d.neg) begin
                mag = ~mag;
            end else begin
                mag = mag;
            end
            row = {{(DEF_PW-DEF_WIDTH-1){mag[DEF_WIDTH]}}, mag} << (2*i);
            acc = acc + (row & keep);
            if (d.neg && ((2*i) >= trunc_cols)) begin
                acc = acc + ({{(DEF_PW-1){1'b0}}, 1'b1} << (2*i));
            end else begin
                acc = acc;
            end
        end
        if (trunc_cols > 0) begin
            acc = acc + ({{(DEF_PW-1){1'b0}}, 1'b1} << (trunc_cols - 1));
        end else begin
            acc = acc;
        end
        return acc;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// booth_pp_gen: one radix-4 Booth digit and its partial-product row.
//   i_a    : multiplicand A (signed, WIDTH bits)
//   i_bits : Booth window {B[2i+1], B[2i], B[2i-1]}
//   o_row  : |d|*A as a WIDTH+1 bit signed value, bitwise inverted when d<0
//   o_neg  : +1 correction bit (weight 2^(2i)) completing the negation
module booth_pp_gen
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [2:0]       i_bits,
    output logic [WIDTH:0]   o_row,
    output logic             o_neg
);

    booth_digit_t   w_dig;
    logic [WIDTH:0] w_mag;

    assign w_dig = booth_recode(i_bits);

    // Magnitude select: 2A is a left shift, A is sign-extended by one bit
    always_comb begin
        w_mag = '0;
        if (w_dig.two) begin
            w_mag = {i_a, 1'b0};
        end else if (w_dig.one) begin
            w_mag = {i_a[WIDTH-1], i_a};
        end else begin
            w_mag = '0;
        end
    end

    // Negative digits emit the one's complement; the +1 travels as o_neg
    always_comb begin
        o_row = w_mag;
        o_neg = w_dig.neg;
        if (w_dig.neg) begin
            o_row = ~w_mag;
        end else begin
            o_row = w_mag;
        end
    end

endmodule

// File: rtl/approx_booth_multiplier.sv
// approx_booth_multiplier: approximate signed WIDTHxWIDTH radix-4 Booth multiplier.
// Partial-product and neg bits below column TRUNC_COLS are dropped and a
// constant 2^(TRUNC_COLS-1) is added back; TRUNC_COLS=0 gives the exact product.
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   in_valid  : A/B valid this cycle
//   A, B      : signed operands (B is Booth recoded)
//   out_valid : out holds a new result (one cycle after in_valid)
//   out       : registered 2*WIDTH-bit approximate product, held when idle
module approx_booth_multiplier
    import approx_mult_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int TRUNC_COLS = DEF_TRUNC_COLS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    output logic [2*WIDTH-1:0] out
);

    localparam int            PW        = 2 * WIDTH;
    localparam int            NDIG      = WIDTH / 2;
    localparam logic [PW-1:0] ONE_W     = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] KEEP_MASK = {PW{1'b1}} << TRUNC_COLS;
    // (1 << T) >> 1 is 2^(T-1) for T>0 and 0 for T=0
    localparam logic [PW-1:0] COMP      = (ONE_W << TRUNC_COLS) >> 1;

    logic [WIDTH:0]  w_b_ext;
    logic [WIDTH:0]  w_row [NDIG];
    logic [NDIG-1:0] w_neg;
    logic [PW-1:0]   w_pp  [NDIG];
    logic [PW-1:0]   w_neg_vec;
    logic [PW-1:0]   w_sum;
    logic [PW-1:0]   r_out;
    logic            r_valid;

    assign w_b_ext = {B, 1'b0};

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_pp
            booth_pp_gen #(
                .WIDTH (WIDTH)
            ) u_pp (
                .i_a    (A),
                .i_bits (w_b_ext[2*g +: 3]),
                .o_row  (w_row[g]),
                .o_neg  (w_neg[g])
            );
            assign w_pp[g] = ({{(PW-WIDTH-1){w_row[g][WIDTH]}}, w_row[g]} << (2*g)) & KEEP_MASK;
        end
    endgenerate

    // Neg bits sit in distinct even columns, so they merge into one addend
    always_comb begin
        w_neg_vec = '0;
        for (int i = 0; i < NDIG; i++) begin
            w_neg_vec[2*i] = w_neg[i];
        end
    end

    // Sum kept rows, kept neg bits and the bias compensation, modulo 2^PW
    always_comb begin
        w_sum = COMP + (w_neg_vec & KEEP_MASK);
        for (int i = 0; i < NDIG; i++) begin
            w_sum = w_sum + w_pp[i];
        end
    end

    // Output stage: capture on in_valid, hold otherwise; reset drops pending data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_out <= w_sum;
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_valid;

endmodule

// File: tb/tb_approx_booth_multiplier.sv
// Scoreboard bench: three DUTs (TRUNC_COLS 0, 4, 8) share one stimulus stream.
// Expected products come from an integer-digit model of the truncated Booth sum.
module tb_approx_booth_multiplier;

    typedef struct packed {
        logic [31:0] e;
        logic [15:0] a;
        logic [15:0] b;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] A = 16'd0;
    logic [15:0] B = 16'd0;
    logic        ov [3];
    logic [31:0] o  [3];
    logic        exp_v;
    logic        stim_done = 1'b0;
    txn_t        q [3][$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    approx_booth_multiplier #(.WIDTH(16), .TRUNC_COLS(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(ov[0]), .out(o[0]));
    approx_booth_multiplier #(.WIDTH(16), .TRUNC_COLS(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(ov[1]), .out(o[1]));
    approx_booth_multiplier #(.WIDTH(16), .TRUNC_COLS(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .out_valid(ov[2]), .out(o[2]));

    function automatic int tcols(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 4 : 8);
    endfunction

    // Digit-level model: d_i in {-2..2} from B's bits, rows as integers.
    function automatic logic [31:0] ref_model(input logic [15:0] a, input logic [15:0] b, input int t);
        logic [16:0] bx;
        longint      acc, mag, row, av;
        logic [63:0] keep;
        int          d, ad;
        bx   = {b, 1'b0};
        av   = longint'($signed(a));
        acc  = 64'sd0;
        keep = (64'h0000_0000_FFFF_FFFF >> t) << t;
        for (int i = 0; i < 8; i++) begin
            d   = (bx[2*i] ? 1 : 0) + (bx[2*i+1] ? 1 : 0) - (bx[2*i+2] ? 2 : 0);
            ad  = (d < 0) ? -d : d;
            mag = av * longint'(ad);
            row = (d < 0) ? ~mag : mag;
            row = row << (2*i);
            acc = acc + longint'(64'(row) & keep);
            if (d < 0 && (2*i) >= t) acc = acc + (64'sd1 << (2*i));
        end
        if (t > 0) acc = acc + (64'sd1 << (t - 1));
        return acc[31:0];
    endfunction

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input int ov_idx, input logic [31:0] ov_val);
        txn_t t;
        @(posedge clk); #1;
        in_valid = 1'b1; A = a; B = b;
        for (int k = 0; k < 3; k++) begin
            t.a = a; t.b = b;
            t.e = (k == ov_idx) ? ov_val : ref_model(a, b, tcols(k));
            q[k].push_back(t);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        in_valid = 1'b0; A = 16'($urandom); B = 16'($urandom);
    endtask

    // Expected out_valid: previous in_valid, cleared asynchronously by rst
    always @(posedge clk or posedge rst) begin
        if (rst) exp_v <= 1'b0;
        else     exp_v <= in_valid;
    end

    // Monitor: sole owner of the counters and the summary line
    initial begin : monitor
        txn_t        tx;
        logic [31:0] last [3];
        longint      e_v, lo, hi;
        real         s_e [3], s_sq [3], mean, var_e;
        int          n_s [3], n_ex [3], drain;
        drain = 0;
        for (int k = 0; k < 3; k++) begin
            last[k] = 32'd0; s_e[k] = 0.0; s_sq[k] = 0.0; n_s[k] = 0; n_ex[k] = 0;
        end
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                #1;
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (ov[k] !== 1'b0 || o[k] !== 32'd0) begin
                        errors++;
                        $display("FAIL reset_state T=%0d: out=%h out_valid=%b, required out=0 out_valid=0",
                                 tcols(k), o[k], ov[k]);
                    end
                    last[k] = 32'd0;
                end
            end else begin
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (ov[k] !== exp_v) begin
                        errors++;
                        $display("FAIL out_valid T=%0d: got %b, required %b", tcols(k), ov[k], exp_v);
                    end
                    if (ov[k] === 1'b1) begin
                        checks++;
                        if (q[k].size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_result T=%0d: out=%h with no pending input", tcols(k), o[k]);
                        end else begin
                            tx = q[k].pop_front();
                            if (o[k] !== tx.e) begin
                                errors++;
                                $display("FAIL product T=%0d A=%0d B=%0d: got %0d, required %0d",
                                         tcols(k), $signed(tx.a), $signed(tx.b), $signed(o[k]), $signed(tx.e));
                            end
                            e_v = longint'($signed(o[k])) - longint'($signed(tx.a)) * longint'($signed(tx.b));
                            hi  = (tcols(k) > 0) ? (64'sd1 <<< (tcols(k) - 1)) : 64'sd0;
                            lo  = (tcols(k) > 0) ? (-64'sd9 * (64'sd1 <<< tcols(k)) + hi) : -64'sd1;
                            checks++;
                            if (!(e_v > lo && e_v <= hi)) begin
                                errors++;
                                $display("FAIL error_bound T=%0d A=%0d B=%0d: E=%0d, required in (%0d,%0d]",
                                         tcols(k), $signed(tx.a), $signed(tx.b), e_v, lo, hi);
                            end
                            s_e[k]  = s_e[k] + real'(e_v);
                            s_sq[k] = s_sq[k] + real'(e_v) * real'(e_v);
                            n_s[k]++;
                            if (e_v == 64'sd0) n_ex[k]++;
                        end
                    end else begin
                        checks++;
                        if (o[k] !== last[k]) begin
                            errors++;
                            $display("FAIL hold T=%0d: out=%h, required held value %h", tcols(k), o[k], last[k]);
                        end
                    end
                    last[k] = o[k];
                end
                if (stim_done) begin
                    drain++;
                    if ((q[0].size() + q[1].size() + q[2].size()) == 0 || drain > 20) begin
                        checks++;
                        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
                            errors++;
                            $display("FAIL drain: %0d results never appeared, required 0",
                                     q[0].size() + q[1].size() + q[2].size());
                        end
                        for (int k = 0; k < 3; k++) begin
                            mean  = (n_s[k] > 0) ? s_e[k] / real'(n_s[k]) : 0.0;
                            var_e = (n_s[k] > 0) ? s_sq[k] / real'(n_s[k]) - mean * mean : 0.0;
                            if (var_e < 0.0) var_e = 0.0;
                            $display("T=%0d samples=%0d mean_err=%f std_err=%f exact_rate=%f",
                                     tcols(k), n_s[k], mean, $sqrt(var_e),
                                     (n_s[k] > 0) ? real'(n_ex[k]) / real'(n_s[k]) : 0.0);
                        end
                        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
                        $finish;
                    end
                end
            end
        end
    end

    // Stimulus
    initial begin : stim
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Exact-mode corners on T=0, truncated corners on T=8
        issue(16'd100,   16'hFF92, 0, 32'hFFFF_D508);
        issue(16'h8000,  16'h8000, 0, 32'h4000_0000);
        issue(16'h7FFF,  16'h8000, 0, 32'hC000_8000);
        issue(16'd0,     16'd0,    2, 32'd128);
        issue(16'h0100,  16'h0100, 2, 32'd65664);

        // Handshake pattern 1,1,0,1
        issue(16'd1234,  16'hF00D, -1, 32'd0);
        issue(16'hBEEF,  16'd77,   -1, 32'd0);
        idle();
        issue(16'd5,     16'hFFFF, -1, 32'd0);
        idle();
        idle();

        // Reset mid-stream with in_valid high and a result pending
        issue(16'd300,   16'd400,  -1, 32'd0);
        issue(16'd999,   16'd111,  -1, 32'd0);
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) q[k].delete();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        issue(16'hFFFE,  16'd3,    -1, 32'd0);
        idle();

        // Random sweep: B fixed at -110, then random B, with occasional gaps
        for (int n = 0; n < 10000; n++) begin
            issue(16'($urandom), 16'hFF92, -1, 32'd0);
            if ($urandom_range(0, 31) == 0) idle();
        end
        for (int n = 0; n < 10000; n++) begin
            issue(16'($urandom), 16'($urandom), -1, 32'd0);
            if ($urandom_range(0, 31) == 0) idle();
        end
        idle();
        stim_done = 1'b1;
    end

    // Watchdog
    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog timeout");
    end

endmodule
